shared_bram_snap_writer: RTL and testbench
==========================================

Name: shared_bram_snap_writer

Overview:
- Fabric-side writer for port A of a shared processor-readable BRAM.
- Captures a triggered burst of a sample stream (e.g. FFT or window output) into the BRAM.
- Raises a done flag so software can read the snapshot through the bus-side port B.
- Drives the port A signals `bram_we`, `bram_en_a`, `bram_addr` and `bram_wr_data` directly.

Parameters:
- ADDR_W, 10, BRAM address width in words; depth = 2^ADDR_W.
- DATA_W, 32, sample and BRAM word width.

Ports:
- clk  input  1  fabric clock; all logic is on its rising edge.
- rst  input  1  synchronous active-high reset.
- arm  input  1  single-cycle pulse; starts or restarts a capture.
- num_words  input  ADDR_W  capture length, sampled on arm; 0 means 2^ADDR_W.
- trig  input  1  start condition; qualified by din_valid.
- din_valid  input  1  din carries a valid sample this cycle.
- din  input  DATA_W  sample data.
- bram_we  output  1  port A write enable.
- bram_en_a  output  1  port A enable.
- bram_addr  output  ADDR_W  port A word address.
- bram_wr_data  output  DATA_W  port A write data.
- busy  output  1  high in ARMED or CAPTURE.
- done  output  1  snapshot complete; held high until the next arm or rst.
- word_count  output  ADDR_W+1  number of words written in the current or last capture.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - bram_we, bram_en_a, busy, done = 0.
  - bram_addr, bram_wr_data, word_count = 0.
  - Latched length = 2^ADDR_W.
- All outputs are registered.
- States:
  - IDLE: waits for arm.
  - ARMED: waits for trig & din_valid.
  - CAPTURE: writes each valid sample.
  - DONE: holds done=1 until arm.
- arm, in any state:
  - Next state is ARMED; done goes to 0 and word_count to 0.
  - num_words is latched, with 0 mapped to 2^ADDR_W.
  - Any write already issued this cycle completes; no further words are written from the aborted capture.
- ARMED:
  - First cycle with trig=1 and din_valid=1 is the trigger sample; it becomes word 0 and the state moves to CAPTURE.
  - trig with din_valid=0 is ignored.
  - din_valid without trig is ignored.
- CAPTURE:
  - Every cycle with din_valid=1 writes one word.
  - trig is ignored.
- Write timing: a sample accepted at edge t produces, in the cycle after t, bram_we=1, bram_en_a=1, bram_addr=word index, bram_wr_data=din.
  - Latency is 1 cycle; throughput is 1 word per cycle.
  - bram_en_a equals bram_we.
  - Both are 0 in cycles without a write.
  - bram_addr and bram_wr_data hold their last values when idle.
- word_count increments in the same cycle bram_we is presented.
- Termination: when the word being written has index = length-1, the state moves to DONE. done=1 and busy=0 appear in the same cycle as that final write.
- Wrap: no address wrap occurs. Indices run from 0 to length-1 (maximum 2^ADDR_W-1), then writes stop. With length = 2^ADDR_W, word_count ends at 2^ADDR_W, which is why it is ADDR_W+1 bits.
- DONE: din_valid and trig are ignored, and no writes are issued.
- arm and trig&din_valid in the same cycle:
  - arm wins; the state goes to ARMED.
  - That sample is not captured.
- rst mid-capture:
  - Returns to IDLE on the next edge.
  - All outputs take their reset values.
  - The partial BRAM contents are left as written.
- rst has priority over arm.

Test Plan:
- Reset, then arm with num_words=4, then trig&din_valid with din=0xA0, followed by valid din 0xA1, 0xA2, 0xA3, 0xA4 -> four writes (addr, data): (0,0xA0), (1,0xA1), (2,0xA2), (3,0xA3), each 1 cycle after its input; done=1 with the addr-3 write; 0xA4 is not written; word_count=4.
- Arm with num_words=0, then trig plus a continuous ramp din=n -> 1024 consecutive writes at addr 0..1023 with data 0..1023; done=1; word_count=1024; no write at addr 0 after addr 1023.
- Gapped din_valid (1,0,0,1,0,1) during capture with num_words=3 -> writes occur only on valid cycles; bram_addr values are 0,1,2; bram_we=0 in the gap cycles.
- trig high while din_valid=0 in ARMED, with valid arriving 2 cycles later and trig low -> no capture starts; busy stays 1; capture starts on the first cycle with trig&din_valid.
- arm pulse after 5 of 8 words (num_words=8 latched) -> word_count reads 0 and done reads 0; the next trig starts again at addr 0 and a full 8-word capture completes.
- rst asserted after 2 of 8 words -> the next cycle shows all outputs 0 and IDLE; trig without arm causes no writes.

Source files
------------

// File: rtl/shared_bram_snap_writer.sv
// Port-A snapshot writer for a shared BRAM: on arm, waits for a qualified trigger,
// then writes num_words valid samples at consecutive addresses and raises done.
module shared_bram_snap_writer #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              trig,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              bram_we,
    output logic              bram_en_a,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] last_idx;

    // Index of the final word of the capture; word_count doubles as the next write index.
    assign last_idx = len - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len          <= DEPTH;
            bram_we      <= 1'b0;
            bram_en_a    <= 1'b0;
            bram_addr    <= '0;
            bram_wr_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            word_count   <= '0;
        end else begin
            bram_we   <= 1'b0;
            bram_en_a <= 1'b0;
            if (arm) begin
                // Arm aborts any capture in flight and wins over a coincident trigger.
                state      <= ARMED;
                len        <= (num_words == '0) ? DEPTH : {1'b0, num_words};
                busy       <= 1'b1;
                done       <= 1'b0;
                word_count <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ARMED: begin
                        if (trig && din_valid) begin
                            bram_we      <= 1'b1;
                            bram_en_a    <= 1'b1;
                            bram_addr    <= '0;
                            bram_wr_data <= din;
                            word_count   <= CNT_W'(1);
                            if (last_idx == '0) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (din_valid) begin
                            bram_we      <= 1'b1;
                            bram_en_a    <= 1'b1;
                            bram_addr    <= word_count[ADDR_W-1:0];
                            bram_wr_data <= din;
                            word_count   <= word_count + CNT_W'(1);
                            if (word_count == last_idx) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shared_bram_snap_writer.sv
// Directed bench for shared_bram_snap_writer: one task per scenario with inline checks.
module tb_shared_bram_snap_writer;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              arm;
    logic [ADDR_W-1:0] num_words;
    logic              trig;
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              bram_we;
    logic              bram_en_a;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wr_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;

    int n_cmp;
    int n_bad;

    shared_bram_snap_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .num_words    (num_words),
        .trig         (trig),
        .din_valid    (din_valid),
        .din          (din),
        .bram_we      (bram_we),
        .bram_en_a    (bram_en_a),
        .bram_addr    (bram_addr),
        .bram_wr_data (bram_wr_data),
        .busy         (busy),
        .done         (done),
        .word_count   (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arm = 1'b0; trig = 1'b0; din_valid = 1'b0;
    endtask

    task automatic do_arm(input logic [ADDR_W-1:0] n);
        idle_inputs();
        arm = 1'b1; num_words = n;
        cycle();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        num_words = '0; din = '0;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        n_cmp++;
        if ({bram_we, bram_en_a, busy, done} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=0000", {bram_we, bram_en_a, busy, done});
        end
        n_cmp++;
        if ({bram_addr, bram_wr_data, word_count} !== '0) begin
            n_bad++; $display("FAIL reset_buses addr=%0d data=%h wc=%0d exp all 0", bram_addr, bram_wr_data, word_count);
        end
        trig = 1'b1; din_valid = 1'b1; din = 32'h77;
        cycle();
        idle_inputs();
        n_cmp++;
        if (bram_we !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_trig_no_arm we=%b busy=%b exp 0 0", bram_we, busy);
        end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] vals [5];
        vals[0] = 32'hA0; vals[1] = 32'hA1; vals[2] = 32'hA2; vals[3] = 32'hA3; vals[4] = 32'hA4;
        do_arm(10'd4);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || bram_we !== 1'b0) begin
            n_bad++; $display("FAIL basic_armed busy=%b done=%b we=%b exp 1 0 0", busy, done, bram_we);
        end
        for (int i = 0; i < 5; i++) begin
            trig = (i == 0); din_valid = 1'b1; din = vals[i];
            cycle();
            if (i < 4) begin
                n_cmp++;
                if (bram_we !== 1'b1 || bram_en_a !== 1'b1 || bram_addr !== 10'(i) || bram_wr_data !== vals[i]) begin
                    n_bad++; $display("FAIL basic_write%0d we=%b en=%b addr=%0d data=%h exp 1 1 %0d %h",
                                      i, bram_we, bram_en_a, bram_addr, bram_wr_data, i, vals[i]);
                end
                n_cmp++;
                if (word_count !== 11'(i + 1) || done !== (i == 3) || busy !== (i != 3)) begin
                    n_bad++; $display("FAIL basic_status%0d wc=%0d done=%b busy=%b exp %0d %b %b",
                                      i, word_count, done, busy, i + 1, (i == 3), (i != 3));
                end
            end else begin
                n_cmp++;
                if (bram_we !== 1'b0 || bram_en_a !== 1'b0 || bram_addr !== 10'd3 || bram_wr_data !== 32'hA3 ||
                    word_count !== 11'd4 || done !== 1'b1) begin
                    n_bad++; $display("FAIL basic_after we=%b en=%b addr=%0d data=%h wc=%0d done=%b exp 0 0 3 a3 4 1",
                                      bram_we, bram_en_a, bram_addr, bram_wr_data, word_count, done);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_full_depth();
        int bad_writes;
        bad_writes = 0;
        do_arm(10'd0);
        for (int n = 0; n < 1024; n++) begin
            trig = (n == 0); din_valid = 1'b1; din = 32'(n);
            cycle();
            if (bram_we !== 1'b1 || bram_addr !== 10'(n) || bram_wr_data !== 32'(n)) bad_writes++;
        end
        n_cmp++;
        if (bad_writes != 0) begin
            n_bad++; $display("FAIL full_ramp bad_writes=%0d exp 0", bad_writes);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || word_count !== 11'd1024) begin
            n_bad++; $display("FAIL full_end done=%b busy=%b wc=%0d exp 1 0 1024", done, busy, word_count);
        end
        din = 32'd1024;
        cycle();
        n_cmp++;
        if (bram_we !== 1'b0 || bram_addr !== 10'd1023 || word_count !== 11'd1024) begin
            n_bad++; $display("FAIL full_nowrap we=%b addr=%0d wc=%0d exp 0 1023 1024", bram_we, bram_addr, word_count);
        end
        idle_inputs();
    endtask

    task automatic test_gapped();
        logic [5:0] pat;
        int exp_idx;
        pat = 6'b101001; // bit i = din_valid at step i: 1,0,0,1,0,1
        exp_idx = 0;
        do_arm(10'd3);
        for (int i = 0; i < 6; i++) begin
            trig = (i == 0); din_valid = pat[i]; din = 32'h100 + 32'(i);
            cycle();
            n_cmp++;
            if (bram_we !== pat[i] || (pat[i] && (bram_addr !== 10'(exp_idx) || bram_wr_data !== 32'h100 + 32'(i)))) begin
                n_bad++; $display("FAIL gapped%0d we=%b addr=%0d data=%h exp %b %0d %h",
                                  i, bram_we, bram_addr, bram_wr_data, pat[i], exp_idx, 32'h100 + 32'(i));
            end
            if (pat[i]) exp_idx++;
        end
        n_cmp++;
        if (done !== 1'b1 || word_count !== 11'd3) begin
            n_bad++; $display("FAIL gapped_end done=%b wc=%0d exp 1 3", done, word_count);
        end
        idle_inputs();
    endtask

    task automatic test_trig_qualify();
        logic [1:0] tv [3];
        tv[0] = 2'b10; tv[1] = 2'b00; tv[2] = 2'b01; // {trig, din_valid}
        do_arm(10'd2);
        for (int i = 0; i < 3; i++) begin
            {trig, din_valid} = tv[i]; din = 32'h50 + 32'(i);
            cycle();
            n_cmp++;
            if (bram_we !== 1'b0 || busy !== 1'b1 || word_count !== 11'd0) begin
                n_bad++; $display("FAIL qual_wait%0d we=%b busy=%b wc=%0d exp 0 1 0", i, bram_we, busy, word_count);
            end
        end
        trig = 1'b1; din_valid = 1'b1; din = 32'h55;
        cycle();
        n_cmp++;
        if (bram_we !== 1'b1 || bram_addr !== 10'd0 || bram_wr_data !== 32'h55) begin
            n_bad++; $display("FAIL qual_start we=%b addr=%0d data=%h exp 1 0 55", bram_we, bram_addr, bram_wr_data);
        end
        trig = 1'b0; din = 32'h56;
        cycle();
        n_cmp++;
        if (bram_addr !== 10'd1 || bram_wr_data !== 32'h56 || done !== 1'b1) begin
            n_bad++; $display("FAIL qual_end addr=%0d data=%h done=%b exp 1 56 1", bram_addr, bram_wr_data, done);
        end
        idle_inputs();
    endtask

    task automatic test_rearm();
        do_arm(10'd8);
        for (int i = 0; i < 5; i++) begin
            trig = (i == 0); din_valid = 1'b1; din = 32'h200 + 32'(i);
            cycle();
        end
        n_cmp++;
        if (word_count !== 11'd5 || bram_addr !== 10'd4) begin
            n_bad++; $display("FAIL rearm_partial wc=%0d addr=%0d exp 5 4", word_count, bram_addr);
        end
        // Re-arm while samples keep coming, with a coincident trigger: arm must win.
        arm = 1'b1; num_words = 10'd8; trig = 1'b1; din_valid = 1'b1; din = 32'h2FF;
        cycle();
        arm = 1'b0; trig = 1'b0; din = 32'h2FE;
        n_cmp++;
        if (word_count !== 11'd0 || done !== 1'b0 || busy !== 1'b1 || bram_we !== 1'b0) begin
            n_bad++; $display("FAIL rearm_clear wc=%0d done=%b busy=%b we=%b exp 0 0 1 0", word_count, done, busy, bram_we);
        end
        cycle();
        n_cmp++;
        if (bram_we !== 1'b0) begin
            n_bad++; $display("FAIL rearm_no_trig we=%b exp 0", bram_we);
        end
        for (int i = 0; i < 8; i++) begin
            trig = (i == 0); din_valid = 1'b1; din = 32'h300 + 32'(i);
            cycle();
            n_cmp++;
            if (bram_we !== 1'b1 || bram_addr !== 10'(i) || bram_wr_data !== 32'h300 + 32'(i) || done !== (i == 7)) begin
                n_bad++; $display("FAIL rearm_write%0d we=%b addr=%0d data=%h done=%b exp 1 %0d %h %b",
                                  i, bram_we, bram_addr, bram_wr_data, done, i, 32'h300 + 32'(i), (i == 7));
            end
        end
        n_cmp++;
        if (word_count !== 11'd8) begin
            n_bad++; $display("FAIL rearm_count wc=%0d exp 8", word_count);
        end
        idle_inputs();
    endtask

    task automatic test_rst_mid();
        do_arm(10'd8);
        for (int i = 0; i < 2; i++) begin
            trig = (i == 0); din_valid = 1'b1; din = 32'h400 + 32'(i);
            cycle();
        end
        rst = 1'b1; arm = 1'b1; trig = 1'b0;
        cycle();
        rst = 1'b0; arm = 1'b0;
        n_cmp++;
        if ({bram_we, bram_en_a, busy, done} !== 4'b0000 || bram_addr !== '0 || bram_wr_data !== '0 || word_count !== '0) begin
            n_bad++; $display("FAIL rst_mid we=%b en=%b busy=%b done=%b addr=%0d data=%h wc=%0d exp all 0",
                              bram_we, bram_en_a, busy, done, bram_addr, bram_wr_data, word_count);
        end
        for (int i = 0; i < 3; i++) begin
            trig = 1'b1; din_valid = 1'b1; din = 32'h500 + 32'(i);
            cycle();
            n_cmp++;
            if (bram_we !== 1'b0 || busy !== 1'b0 || word_count !== '0) begin
                n_bad++; $display("FAIL rst_idle%0d we=%b busy=%b wc=%0d exp 0 0 0", i, bram_we, busy, word_count);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        idle_inputs();
        num_words = '0;
        din = '0;
        test_reset();
        test_basic();
        test_full_depth();
        test_gapped();
        test_trig_qualify();
        test_rearm();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
